// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes MIPS R-type/LUI words, drives an external
// combinational ALU, and writes results back to a 32x32 register file.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        done,
  output logic        err_illegal,
  output logic        exc_ovf,
  output logic        flag_zero,
  output logic        flag_carry,
  output logic        flag_negative,
  output logic        flag_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;

  state_t      state;
  logic [31:0] rf [32];
  logic [31:0] instr;
  logic [31:0] result;
  logic [4:0]  dest;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  logic        funct_ok;
  logic        is_shamt;
  logic        is_r;
  logic        is_lui;
  logic        legal;
  logic [31:0] a_n;
  logic [31:0] b_n;
  logic [5:0]  aluc_n;
  logic [4:0]  dest_n;

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011, 6'b000000, 6'b000010,
      6'b000011, 6'b000100, 6'b000110, 6'b000111:
        funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
    is_shamt = (funct == 6'b000000) || (funct == 6'b000010)
            || (funct == 6'b000011);
    is_r   = (opcode == OP_R) && funct_ok;
    is_lui = (opcode == OP_LUI);
    legal  = is_r || is_lui;
    a_n    = '0;
    b_n    = '0;
    aluc_n = '0;
    dest_n = '0;
    unique case (1'b1)
      is_r: begin
        aluc_n = funct;
        dest_n = rd;
        a_n    = is_shamt ? {27'b0, shamt} : rf[rs];
        b_n    = rf[rt];
      end
      is_lui: begin
        aluc_n = OP_LUI;
        dest_n = rt;
        a_n    = {16'b0, imm};
      end
      default: ;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      instr         <= '0;
      result        <= '0;
      dest          <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_aluc      <= '0;
      done          <= 1'b0;
      err_illegal   <= 1'b0;
      exc_ovf       <= 1'b0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_negative <= 1'b0;
      flag_overflow <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      done        <= 1'b0;
      err_illegal <= 1'b0;
      exc_ovf     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            instr <= in_instr;
            state <= DECODE;
          end else if (cfg_we && cfg_addr != 5'd0) begin
            rf[cfg_addr] <= cfg_wdata;
          end
        end
        DECODE: begin
          if (legal) begin
            alu_a    <= a_n;
            alu_b    <= b_n;
            alu_aluc <= aluc_n;
            dest     <= dest_n;
            state    <= EXEC;
          end else begin
            err_illegal <= 1'b1;
            state       <= IDLE;
          end
        end
        EXEC: begin
          result        <= alu_r;
          flag_zero     <= alu_zero;
          flag_carry    <= alu_carry;
          flag_negative <= alu_negative;
          flag_overflow <= alu_overflow;
          state         <= WB;
        end
        WB: begin
          done  <= 1'b1;
          state <= IDLE;
          // Only signed ADD/SUB trap; unsigned forms wrap silently
          if ((alu_aluc == F_ADD || alu_aluc == F_SUB) && flag_overflow)
            exc_ovf <= 1'b1;
          else if (dest != 5'd0)
            rf[dest] <= result;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with a behavioural ALU and
// register-file reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_aluc;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_negative;
  logic        alu_overflow;
  logic        done;
  logic        err_illegal;
  logic        exc_ovf;
  logic        flag_zero;
  logic        flag_carry;
  logic        flag_negative;
  logic        flag_overflow;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .done(done), .err_illegal(err_illegal), .exc_ovf(exc_ovf),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_negative(flag_negative), .flag_overflow(flag_overflow)
  );

  // returns {zero, carry, negative, overflow, result}
  function automatic logic [35:0] alu_model(
    input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      6'h20, 6'h21: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      6'h22, 6'h23: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2b: r = (a < b) ? 32'd1 : 32'd0;
      6'h00, 6'h04: r = b << a[4:0];
      6'h02, 6'h06: r = b >> a[4:0];
      6'h03, 6'h07: r = $signed(b) >>> a[4:0];
      6'h0f: r = a << 16;
      default: r = '0;
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  assign {alu_zero, alu_carry, alu_negative, alu_overflow, alu_r} =
    alu_model(alu_aluc, alu_a, alu_b);

  logic [31:0] ref_rf [32];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic predict(input logic [31:0] ins, output bit legal,
                         output logic [5:0] ac, output logic [31:0] a,
                         output logic [31:0] b, output logic [4:0] d);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    legal = 1'b0; ac = '0; a = '0; b = '0; d = '0;
    if (op == 6'h00 && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
        6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04,
        6'h06, 6'h07})) begin
      legal = 1'b1;
      ac = fn;
      d = ins[15:11];
      b = ref_rf[ins[20:16]];
      a = (fn inside {6'h00, 6'h02, 6'h03}) ? {27'b0, ins[10:6]}
                                            : ref_rf[ins[25:21]];
    end else if (op == 6'h0f) begin
      legal = 1'b1;
      ac = 6'h0f;
      d = ins[20:16];
      a = {16'b0, ins[15:0]};
    end
  endtask

  task automatic dbg_chk(input logic [4:0] r);
    dbg_addr = r;
    #1;
    chk($sformatf("rf%0d", r), dbg_data, ref_rf[r]);
  endtask

  task automatic sweep();
    for (int i = 0; i < 32; i++) dbg_chk(5'(i));
  endtask

  task automatic cfg(input logic [4:0] r, input logic [31:0] v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = r; cfg_wdata = v;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (r != 5'd0) ref_rf[r] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_aluc", alu_aluc, 0);
    chk("rst_flags", {flag_zero, flag_carry, flag_negative, flag_overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // noise drives cfg_we while the instruction is accepted and in flight
  task automatic issue(input logic [31:0] ins, input bit noise);
    bit          legal;
    bit          ovf;
    logic [5:0]  ac;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [35:0] o;
    predict(ins, legal, ac, a, b, d);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins;
    cfg_we = noise; cfg_addr = 5'($urandom_range(1, 31));
    cfg_wdata = $urandom;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("busy_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    if (!legal) begin
      cfg_we = 1'b0;
      chk("ill_pulse", err_illegal, 1);
      chk("ill_done", done, 0);
      chk("ill_rdy", in_ready, 1);
      @(posedge clk);
      #1 chk("ill_clear", err_illegal, 0);
      return;
    end
    chk("aluc", alu_aluc, ac);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    @(posedge clk);
    #1;
    chk("done_early", done, 0);
    chk("aluc_hold", alu_aluc, ac);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    o = alu_model(ac, a, b);
    ovf = (ac == 6'h20 || ac == 6'h22) && o[32];
    chk("done", done, 1);
    chk("exc_ovf", exc_ovf, ovf);
    chk("no_err", err_illegal, 0);
    chk("flags", {flag_zero, flag_carry, flag_negative, flag_overflow},
        o[35:32]);
    if (!ovf && d != 5'd0) ref_rf[d] = o[31:0];
    dbg_chk(d);
    @(posedge clk);
    #1 chk("done_clr", done, 0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'h7fffffff;
      1: return 32'h80000000;
      2: return 32'(($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    logic [5:0]  fl [16];
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
           6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    do_reset();
    sweep();
    chk("idle_rdy", in_ready, 1);
    chk("idle_done", done, 0);

    cfg(5'd1, 32'd5);
    cfg(5'd2, 32'd3);
    issue(32'h00221820, 1'b0);
    dbg_chk(5'd3);
    chk("add_r3", dbg_data, 32'd8);
    chk("add_fz", flag_zero, 0);

    cfg(5'd1, 32'h1234);
    cfg(5'd2, 32'h1234);
    issue(32'h00221822, 1'b0);
    dbg_addr = 5'd3;
    #1 chk("sub_r3", dbg_data, 32'd0);
    chk("sub_fz", flag_zero, 1);

    cfg(5'd1, 32'h7fffffff);
    cfg(5'd2, 32'd1);
    cfg(5'd3, 32'haa);
    issue(32'h00221820, 1'b0);
    dbg_addr = 5'd3;
    #1 chk("ovf_r3", dbg_data, 32'haa);

    issue(32'h20000000, 1'b0);
    cfg(5'd0, 32'hdead);
    issue(32'h3C00BEEF, 1'b0);
    dbg_addr = 5'd0;
    #1 chk("lui_r0", dbg_data, 32'd0);
    issue(32'h3C01BEEF, 1'b0);
    dbg_addr = 5'd1;
    #1 chk("lui_r1", dbg_data, 32'hbeef0000);
    sweep();

    for (int k = 0; k < 60; k++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: cfg(5'($urandom_range(0, 31)), rand_val());
        3, 4, 5, 6: begin
          ins[31:26] = 6'h00;
          ins[5:0] = fl[$urandom_range(0, 15)];
          issue(ins, 1'($urandom_range(0, 1)));
        end
        7: begin
          ins[31:26] = 6'h0f;
          issue(ins, 1'($urandom_range(0, 1)));
        end
        8: begin
          ins[31:26] = 6'h00;
          issue(ins, 1'b0);
        end
        default: issue(ins, 1'b0);
      endcase
    end
    sweep();

    // reset while the second instruction sits in EXEC
    cfg(5'd2, 32'h55);
    issue(32'h3C01BEEF, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h3C02BEEF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    #1;
    chk("mid_rdy", in_ready, 1);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_done", done, 0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("mid_nopulse", {done, err_illegal, exc_ovf}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("post_nopulse", {done, err_illegal, exc_ovf}, 0);
    end
    chk("post_rdy", in_ready, 1);
    sweep();
    cfg(5'd4, 32'd9);
    issue(32'h00042820, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
